// File: rtl/wc_tile_sequencer_pkg.sv
// Shared constants and types for the Winograd-core tile sequencer.
// The chip-level integration imports these too, so the defaults are defined once.
package wc_tile_sequencer_pkg;
  localparam int N_ELEM_DEF = 10;
  localparam int DW_DEF     = 8;
  localparam int ZW_DEF     = 5;
  localparam int WC_LAT_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} wc_state_e;

  // The lane index needs at least one bit, even for a single-lane tile.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W_DEF = idx_w(N_ELEM_DEF);
endpackage

// File: rtl/wc_tile_sequencer_if.sv
// Sample-in / result-out streaming handshakes of the tile sequencer.
interface wc_tile_sequencer_if #(
  parameter int DW = 8,
  parameter int ZW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [ZW-1:0] out_data;
  logic          out_last;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/wc_tile_sequencer.sv
// Gathers one tile of serial samples into wc_d, waits out the WC latency,
// then streams the captured wc_z lanes to the downstream port.
module wc_tile_sequencer
  import wc_tile_sequencer_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int DW     = DW_DEF,
  parameter int ZW     = ZW_DEF,
  parameter int WC_LAT = WC_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  wc_tile_sequencer_if.slave     io,
  output logic [N_ELEM*DW-1:0]   wc_d,
  input  logic [N_ELEM*ZW-1:0]   wc_z,
  output logic                   busy,
  output logic [CNT_W-1:0]       tile_cnt
);
  localparam int K_W    = idx_w(N_ELEM);
  localparam int WCNT_W = idx_w(WC_LAT) + 1;
  localparam logic [K_W-1:0]    LAST_LANE = K_W'(N_ELEM - 1);
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WC_LAT - 1);

  wc_state_e             state;
  logic [K_W-1:0]        k;
  logic [K_W-1:0]        j;
  logic [WCNT_W-1:0]     wait_cnt;
  logic [N_ELEM*ZW-1:0]  z_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      j        <= '0;
      wait_cnt <= '0;
      wc_d     <= '0;
      z_reg    <= '0;
      tile_cnt <= '0;
    end else if (clear) begin
      // Abort drops any same-cycle handshake; wc_d and tile_cnt survive.
      state    <= IDLE;
      k        <= '0;
      j        <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: state <= LOAD;
        LOAD: if (io.in_valid) begin
          wc_d[k*DW +: DW] <= io.in_data;
          if (k == LAST_LANE) begin
            k        <= '0;
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end else begin
            k <= k + K_W'(1);
          end
        end
        WAIT: if (wait_cnt == '0) begin
          z_reg <= wc_z;
          state <= DRAIN;
        end else begin
          wait_cnt <= wait_cnt - WCNT_W'(1);
        end
        DRAIN: if (io.out_ready) begin
          if (j == LAST_LANE) begin
            j        <= '0;
            tile_cnt <= tile_cnt + CNT_W'(1);
            state    <= LOAD;
          end else begin
            j <= j + K_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags come from the state register alone, so there is no
  // combinational path from in_valid or out_ready back out of the block.
  assign io.in_ready  = (state == LOAD);
  assign io.out_valid = (state == DRAIN);
  assign io.out_last  = (state == DRAIN) && (j == LAST_LANE);
  assign io.out_data  = z_reg[j*ZW +: ZW];
  assign busy         = (state == WAIT) || (state == DRAIN);
endmodule

// File: tb/tb_wc_tile_sequencer.sv
// Randomised scoreboard bench for wc_tile_sequencer with a behavioural WC model.
module tb_wc_tile_sequencer;
  localparam int N_ELEM = 10;
  localparam int DW     = 8;
  localparam int ZW     = 5;
  localparam int WC_LAT = 2;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic [N_ELEM*DW-1:0] wc_d;
  logic [N_ELEM*ZW-1:0] wc_z;
  logic busy;
  logic [CNT_W-1:0] tile_cnt;

  wc_tile_sequencer_if #(.DW(DW), .ZW(ZW)) ifc ();

  wc_tile_sequencer #(.N_ELEM(N_ELEM), .DW(DW), .ZW(ZW), .WC_LAT(WC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .io(ifc),
    .wc_d(wc_d), .wc_z(wc_z), .busy(busy), .tile_cnt(tile_cnt));

  always #5 clk = ~clk;

  // WC model: z lane = (d lane mod 32) + 1, valid WC_LAT(=2) edges after D changes.
  logic [N_ELEM*DW-1:0] d_dly;
  always @(posedge clk) d_dly <= wc_d;
  always_comb begin
    wc_z = '0;
    for (int i = 0; i < N_ELEM; i++)
      wc_z[i*ZW +: ZW] = ZW'((int'(d_dly[i*DW +: DW]) % 32 + 1) % 32);
  end

  typedef struct { logic [ZW-1:0] d; logic last; } exp_t;
  exp_t exp_q[$];
  int   cur_tile[$];
  int   lanes[N_ELEM];
  int   exp_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = -1;
  logic prev_ov = 1'b0;
  bit   bp = 0;
  int   omode = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  function automatic logic [N_ELEM*DW-1:0] packed_lanes();
    logic [N_ELEM*DW-1:0] p = '0;
    for (int i = 0; i < N_ELEM; i++) p[i*DW +: DW] = DW'(lanes[i]);
    return p;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur_tile.delete();
    for (int i = 0; i < N_ELEM; i++) lanes[i] = 0;
    exp_cnt  = 0;
    last_acc = -1;
    prev_ov  = 1'b0;
  endtask

  // Monitor: compare first, then apply the handshakes the coming edge will perform.
  task automatic mon_step();
    exp_t e;
    cyc++;
    if (!rst) begin
      chk("rst_in_ready", ifc.in_ready, 0);
      chk("rst_out_valid", ifc.out_valid, 0);
      chk("rst_out_last", ifc.out_last, 0);
      chk("rst_out_data", ifc.out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tile_cnt", tile_cnt, 0);
      chk("rst_wc_d", wc_d, 0);
      model_reset();
    end else begin
      chk("tile_cnt", tile_cnt, exp_cnt);
      chk("wc_d", wc_d, packed_lanes());
      chk("in_ready_vs_busy", ifc.in_ready && busy, 0);
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", ifc.out_valid, 0);
        end else begin
          chk("out_data", ifc.out_data, exp_q[0].d);
          chk("out_last", ifc.out_last, exp_q[0].last);
        end
        if (!prev_ov && last_acc >= 0)
          chk("latency", cyc - last_acc, WC_LAT + 1);
      end
      prev_ov = ifc.out_valid;
      if (clear) begin
        exp_q.delete();
        cur_tile.delete();
        last_acc = -1;
      end else begin
        if (ifc.out_valid && ifc.out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.last) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        end
        if (ifc.in_valid && ifc.in_ready) begin
          lanes[cur_tile.size()] = int'(ifc.in_data);
          cur_tile.push_back(int'(ifc.in_data));
          if (cur_tile.size() == N_ELEM) begin
            for (int i = 0; i < N_ELEM; i++) begin
              e.d    = ZW'((cur_tile[i] % 32 + 1) % 32);
              e.last = (i == N_ELEM - 1);
              exp_q.push_back(e);
            end
            cur_tile.delete();
            last_acc = cyc;
          end
        end
      end
    end
  endtask

  always @(negedge clk) mon_step();

  always @(posedge clk) begin
    #1;
    case (omode)
      0: ifc.out_ready = 1'b1;
      1: ifc.out_ready = 1'($urandom % 2);
      default: ifc.out_ready = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    bit acc;
    int n;
    if (bp) repeat ($urandom_range(0, 2)) step();
    ifc.in_valid = 1'b1;
    ifc.in_data  = DW'(x);
    n = 0;
    forever begin
      acc = ifc.in_ready;
      step();
      if (acc) break;
      n++;
      if (n > 500) begin timeout("send"); break; end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_seq(input int base);
    for (int i = 0; i < N_ELEM; i++) send(base + i);
  endtask

  task automatic send_rand();
    for (int i = 0; i < N_ELEM; i++) send(int'($urandom_range(0, 255)));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_q.size() == 0 && ifc.in_ready === 1'b1)) begin
      step();
      n++;
      if (n > 1000) begin timeout("wait_done"); break; end
    end
  endtask

  initial begin
    int cnt_before;
    int n;
    int wrap_seq[5];
    wrap_seq = '{1, 2, 3, 0, 1};
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    ifc.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Single tile 1..10
    send_seq(1);
    wait_done();
    chk("t1_wc_d", wc_d, 80'h0A090807060504030201);
    chk("t1_tile_cnt", tile_cnt, 1);

    // Backpressure on both sides
    bp = 1; omode = 1;
    send_seq(1);
    for (int t = 0; t < 4; t++) send_rand();
    wait_done();
    bp = 0; omode = 0;
    step();

    // Clear after 4 samples, then a fresh tile
    for (int i = 0; i < 4; i++) send(100 + i);
    clear = 1'b1; step(); clear = 1'b0;
    send_seq(20);
    wait_done();

    // Clear on the final output handshake
    cnt_before = int'(tile_cnt);
    send_seq(40);
    n = 0;
    while (!(ifc.out_last === 1'b1)) begin
      step(); n++;
      if (n > 200) begin timeout("wait_last"); break; end
    end
    clear = 1'b1; step(); clear = 1'b0;
    step();
    wait_done();
    chk("clear_last_tile_cnt", tile_cnt, cnt_before);

    // Reset in the middle of DRAIN (j=5 shows value 7)
    send_seq(1);
    n = 0;
    while (!(ifc.out_valid === 1'b1 && ifc.out_data === 5'd7)) begin
      step(); n++;
      if (n > 200) begin timeout("wait_j5"); break; end
    end
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_in_ready", ifc.in_ready, 0);
    @(negedge clk);
    chk("post_rst_load_in_ready", ifc.in_ready, 1);
    step();
    send_seq(1);
    wait_done();
    chk("post_rst_tile_cnt", tile_cnt, 1);

    // Counter wrap from a clean reset
    rst = 1'b0; step(); rst = 1'b1; step(); step();
    for (int t = 0; t < 5; t++) begin
      send_rand();
      wait_done();
      chk("wrap_tile_cnt", tile_cnt, wrap_seq[t]);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
